// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register.
//   NOP_INSTR / NOP_OPCODE : encoding of the pipeline bubble instruction.
//   CNT_W_DEFAULT          : default width of the performance counters.
//   stage_state_t          : occupancy of a stage register (empty / main / main+skid).
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'hFC00_0000;
  localparam logic [5:0]  NOP_OPCODE    = 6'h3F;
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } stage_state_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : count one event this cycle
//   clr_i  : synchronous clear, wins over inc_i
//   cnt_o  : current count, sticks at all-ones
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Valid/ready handshake on both sides, optional two-entry skid buffer, hazard hold,
// flush-to-bubble and saturating stall/flush counters.
//   clk_i, rst_ni          : clock and asynchronous active-low reset
//   in_valid_i/in_ready_o  : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i: downstream handshake, out_data_o payload (BUBBLE when invalid)
//   hold_i                 : hazard stall, freezes contents and masks both handshakes
//   flush_i                : squash held and incoming payloads
//   stall_cnt_o            : cycles with downstream backpressure or hold
//   flush_cnt_o            : cycles where a flush destroyed a valid entry
//   clr_cnt_i              : synchronous clear of both counters
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = 64'hFC00_0000_0000_0000,
  parameter bit                SKID   = 1'b1,
  parameter int unsigned       CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  input  logic              clr_cnt_i
);

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              held_valid;
  logic              in_xfer, out_xfer;
  logic              stall_inc, flush_kill;

  assign held_valid = (state_q != StEmpty);

  // hold masks the port handshakes only; the internal valid survives and reappears.
  assign out_valid_o = held_valid & ~hold_i;
  assign out_data_o  = out_valid_o ? main_q : BUBBLE;

  // in_ready_q is 0 in reset and 1 from the first edge after release. Without the skid
  // buffer it only qualifies the combinational out_ready -> in_ready path.
  assign in_ready_o = in_ready_q & ~hold_i & (SKID ? 1'b1 : (~held_valid | out_ready_i));

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  // Under hold both transfers are already masked, so the case below leaves state alone.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // An out-transfer this cycle has already been sampled downstream; the incoming
      // payload is simply not captured.
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            state_d = StOne;
            main_d  = in_data_i;
          end
        end
        StOne: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (in_xfer && SKID) begin
            state_d = StTwo;
            skid_d  = in_data_i;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_xfer) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = SKID ? (state_d != StTwo) : 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Payload is masked by the bubble mux whenever invalid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign stall_inc = (out_valid_o & ~out_ready_i) | hold_i;

  // A main entry that leaves on the flush edge is delivered, not killed.
  assign flush_kill = flush_i & ((state_q == StTwo) | ((state_q == StOne) & ~out_xfer));

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (stall_inc),
    .clr_i (clr_cnt_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc_i (flush_kill),
    .clr_i (clr_cnt_i),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (SKID=1, CNT_W=4). A queue-based reference
// model holds the expected contents; entries are pushed when the model accepts input
// and popped when the model expects an output transfer.
module tb_pipe_stage_reg;

  localparam int unsigned CntW   = 4;
  localparam logic [63:0] Bubble = 64'hFC00_0000_0000_0000;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic            hold, flush, clr_cnt;
  logic [63:0]     in_data, out_data;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb[$];
  bit          m_rdy;
  int          m_stall, m_flush;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(
    .DATA_W(64),
    .BUBBLE(Bubble),
    .SKID  (1'b1),
    .CNT_W (CntW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .hold_i     (hold),
    .flush_i    (flush),
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt),
    .clr_cnt_i  (clr_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    sb.delete();
    m_rdy   = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  task automatic drive(input bit v, input logic [63:0] d, input bit ordy, input bit h,
                       input bit f, input bit c);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    hold      = h;
    flush     = f;
    clr_cnt   = c;
  endtask

  // Compare outputs for the current inputs, then advance the model across one edge.
  task automatic tick();
    bit          e_ir, e_ov, in_x, out_x, st_inc, kill;
    logic [63:0] e_od;
    #1;
    e_ir = m_rdy && !hold;
    e_ov = (sb.size() > 0) && !hold;
    e_od = e_ov ? sb[0] : Bubble;
    check_eq("in_ready", 64'(in_ready), 64'(e_ir));
    check_eq("out_valid", 64'(out_valid), 64'(e_ov));
    check_eq("out_data", out_data, e_od);
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check_eq("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    in_x   = in_valid && e_ir;
    out_x  = e_ov && out_ready;
    st_inc = (e_ov && !out_ready) || hold;
    kill   = flush && ((sb.size() == 2) || ((sb.size() == 1) && !out_x));
    @(posedge clk_i);
    if (!rst_ni) begin
      model_reset();
    end else begin
      if (out_x) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (in_x) sb.push_back(in_data);
      m_rdy = (sb.size() != 2);
      if (clr_cnt) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (st_inc && m_stall < 15) m_stall++;
        if (kill && m_flush < 15) m_flush++;
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    drive(0, 64'h0, 0, 0, 0, 0);
    model_reset();

    // Reset held for three cycles, then one idle cycle with in_ready still low.
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 64'(i), 1, 0, 0, 0);
      tick();
    end
    drive(0, 64'h0, 1, 0, 0, 0);
    repeat (2) tick();

    // Backpressure: A and B fill main+skid, C waits until space frees.
    drive(0, 64'h0, 1, 0, 0, 1);
    tick();
    drive(1, 64'hA, 0, 0, 0, 0);
    tick();
    drive(1, 64'hB, 0, 0, 0, 0);
    tick();
    drive(1, 64'hC, 0, 0, 0, 0);
    repeat (3) tick();
    drive(1, 64'hC, 1, 0, 0, 0);
    repeat (2) tick();
    drive(0, 64'h0, 1, 0, 0, 0);
    repeat (2) tick();
    check_eq("bp_stall_total", 64'(stall_cnt), 64'd4);

    // Hold for four cycles with 0x1234 in main.
    drive(1, 64'h1234, 0, 0, 0, 1);
    tick();
    drive(1, 64'hDEAD, 1, 1, 0, 0);
    repeat (4) tick();
    drive(0, 64'h0, 0, 0, 0, 0);
    #1;
    check_eq("hold_release_valid", 64'(out_valid), 64'd1);
    check_eq("hold_release_data", out_data, 64'h1234);
    check_eq("hold_stall", 64'(stall_cnt), 64'd4);
    tick();
    drive(0, 64'h0, 1, 0, 0, 0);
    repeat (2) tick();

    // Flush while two entries are held and a new word is offered.
    drive(1, 64'hA1, 0, 0, 0, 1);
    tick();
    drive(1, 64'hA2, 0, 0, 0, 0);
    tick();
    drive(1, 64'hBAD, 0, 0, 1, 0);
    tick();
    drive(0, 64'h0, 1, 0, 0, 0);
    #1;
    check_eq("flush_empty", 64'(out_valid), 64'd0);
    check_eq("flush_opcode", 64'(out_data[63:58]), 64'h3F);
    check_eq("flush_cnt_one", 64'(flush_cnt), 64'd1);
    repeat (2) tick();

    // Flush beats hold and a ready input; hold alone keeps contents.
    drive(1, 64'hC1, 0, 0, 0, 0);
    tick();
    drive(1, 64'hC2, 0, 1, 1, 0);
    tick();
    drive(0, 64'h0, 1, 0, 0, 0);
    repeat (2) tick();
    drive(1, 64'hD1, 0, 0, 0, 0);
    tick();
    drive(1, 64'hD2, 1, 1, 0, 0);
    repeat (2) tick();
    drive(0, 64'h0, 1, 0, 0, 0);
    repeat (2) tick();

    // Flush in the same cycle as an out-transfer: delivered, not counted as killed.
    drive(1, 64'hF1, 0, 0, 0, 1);
    tick();
    drive(1, 64'hF2, 1, 0, 1, 0);
    tick();
    drive(0, 64'h0, 1, 0, 0, 0);
    tick();
    check_eq("flush_deliver_cnt", 64'(flush_cnt), 64'd0);

    // Saturation of the 4-bit stall counter, then clear during a stall.
    drive(0, 64'h0, 0, 1, 0, 1);
    tick();
    drive(0, 64'h0, 0, 1, 0, 0);
    repeat (20) tick();
    check_eq("stall_sat", 64'(stall_cnt), 64'd15);
    drive(0, 64'h0, 0, 1, 0, 1);
    tick();
    check_eq("stall_clr_wins", 64'(stall_cnt), 64'd0);
    drive(0, 64'h0, 1, 0, 0, 0);
    tick();

    // Asynchronous reset with two entries held.
    drive(1, 64'hE1, 0, 0, 0, 0);
    tick();
    drive(1, 64'hE2, 0, 0, 0, 0);
    tick();
    drive(0, 64'h0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_data", out_data, Bubble);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    drive(1, 64'h77, 1, 0, 0, 0);
    tick();
    drive(0, 64'h0, 1, 0, 0, 0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register; successor to the fixed IF/ID latch.
- Usable at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshake, optional 2-entry skid buffer, flush-to-bubble with configurable bubble word, and saturating stall/flush event counters for performance debug.
- Sits between two stages; the hazard unit drives hold and flush.

Parameters:
- DATA_W, 64: payload width in bits. IF/ID instance packs {instr[31:0], nextpc[31:0]}.
- BUBBLE, 64'hFC00_0000_0000_0000: payload presented when the stage is empty or flushed (NOP opcode 6'h3F in the top bits).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is a real instruction.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  payload; equals BUBBLE when out_valid=0.
- hold  in  1  hazard stall; freezes all contents (replaces IFIDWrite=0).
- flush  in  1  squash all held and incoming payloads.
- stall_cnt  out  CNT_W  cycles where out_valid & !out_ready, or hold=1.
- flush_cnt  out  CNT_W  cycles where flush=1 killed at least one valid entry.
- clr_cnt  in  1  synchronous clear of both counters.

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid.
  - out_valid=0, out_data=BUBBLE.
  - in_ready=0 while rst_n=0; 1 from the first clock edge after release.
  - Counters 0.
- Handshake:
  - Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready, both at the rising edge.
  - out_data is stable while out_valid & !out_ready.
  - Latency: 1 cycle in to out when empty.
  - Sustained throughput is 1/cycle when out_ready=1.
- State machine (SKID=1): EMPTY, ONE (main full), TWO (main + skid full).
  - EMPTY: in-transfer -> ONE.
  - ONE:
    - in-transfer without out-transfer -> TWO (payload to skid).
    - out-transfer without in-transfer -> EMPTY.
    - both -> ONE (main loads in_data).
  - TWO:
    - in_ready=0.
    - out-transfer -> ONE; skid moves to main on the same edge.
  - in_ready is a register equal to (next state != TWO).
- SKID=0:
  - States EMPTY and ONE only.
  - in_ready = !out_valid | out_ready (combinational), gated by !hold.
- hold=1:
  - No state, data or valid change.
  - in_ready forced 0 and out_valid forced 0 at the port.
  - Internal valid is preserved and reappears when hold drops.
- flush=1:
  - On the edge, all entries become invalid → EMPTY.
  - A simultaneous in_data is discarded.
  - flush beats hold and beats any in-transfer.
  - An out-transfer in the same cycle still completes (downstream already sampled it).
- out_data mux: main entry when valid, else BUBBLE. Never X after reset.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_cnt beats increment in the same cycle.
  - stall_cnt increments at most 1 per cycle even when both conditions are true.
- Reset mid-operation: any state → EMPTY immediately and asynchronously. Payload registers may retain stale data but are masked by the BUBBLE mux.
- No combinational path in→out when SKID=1. When SKID=0, the only combinational path is out_ready→in_ready.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR = 32'hFC00_0000.
  - NOP_OPCODE = 6'h3F.
  - Typedef stage_state_t {EMPTY, ONE, TWO}.
  - Default CNT_W.
- One sub-module: pipe_sat_cnt (CNT_W-wide saturating counter with inc and clr), instantiated twice.

Test Plan:
- Reset then stream: rst_n low 3 cycles; in_valid=1 with data 1..8, out_ready=1 → out_data 1..8 on consecutive cycles starting 1 cycle after first accept; out_valid=0 and out_data=BUBBLE during reset.
- Backpressure (SKID=1): out_ready=0 while pushing A, B, C → A and B accepted, in_ready=0 with C pending; release out_ready → A, B, C in order, nothing lost or duplicated; stall_cnt equals the number of out_ready=0 cycles.
- Hold: hold=1 for 4 cycles with main holding 0x1234 → out_valid=0, in_ready=0; after release, out_data=0x1234 valid; stall_cnt += 4.
- Flush in TWO with in_valid=1 → next cycle EMPTY, out_data=BUBBLE (top 6 bits 6'h3F), flush_cnt=1; the incoming word never appears.
- Flush+hold+in_valid in the same cycle → flush wins, EMPTY; hold+in_valid without flush → contents unchanged.
- Counter saturation (CNT_W=4): 20 stall cycles → stall_cnt=15; clr_cnt together with a stall → 0.
